// File: rtl/mem_issue_queue_pkg.sv
// Shared types and widths for the in-order memory issue queue.
// Register, operand and ROB widths mirror the core-wide defines.
package mem_issue_queue_pkg;

  localparam int PREG_W    = 6;
  localparam int XLEN      = 64;
  localparam int ROB_W     = 5;
  localparam int LS_SIZE_W = 4;
  localparam int NUM_WB    = 2;

  typedef struct packed {
    logic valid;
    logic rdy1;
    logic rdy2;
  } iq_ctl_t;

  typedef struct packed {
    logic [PREG_W-1:0]    prd;
    logic [PREG_W-1:0]    prs1;
    logic [PREG_W-1:0]    prs2;
    logic [XLEN-1:0]      src1;
    logic [XLEN-1:0]      src2;
    logic [XLEN-1:0]      imm;
    logic                 is_load;
    logic                 is_store;
    logic                 is_unsigned;
    logic [LS_SIZE_W-1:0] ls_size;
    logic                 robidx_flag;
    logic [ROB_W-1:0]     robidx;
  } iq_pay_t;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } wake_t;

  // Lower-numbered ports are applied last so wb0 wins a double match; preg 0 never wakes.
  function automatic wake_t wake_sel(input logic [PREG_W-1:0] prs,
                                     input logic [NUM_WB-1:0] wb_valid,
                                     input logic [NUM_WB-1:0][PREG_W-1:0] wb_prd,
                                     input logic [NUM_WB-1:0][XLEN-1:0] wb_data);
    wake_t w;
    w.hit  = 1'b0;
    w.data = '0;
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (wb_valid[k] && (wb_prd[k] == prs) && (prs != '0)) begin
        w.hit  = 1'b1;
        w.data = wb_data[k];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_issue_queue_if.sv
// Issue port from the memory issue queue to memblock.
interface mem_issue_queue_if;
  import mem_issue_queue_pkg::*;

  logic                 instr_valid;
  logic                 instr_ready;
  logic [PREG_W-1:0]    prd;
  logic [XLEN-1:0]      imm;
  logic [XLEN-1:0]      src1;
  logic [XLEN-1:0]      src2;
  logic                 is_load;
  logic                 is_store;
  logic                 is_unsigned;
  logic [LS_SIZE_W-1:0] ls_size;
  logic                 robidx_flag;
  logic [ROB_W-1:0]     robidx;

  modport master (
    output instr_valid, prd, imm, src1, src2, is_load, is_store, is_unsigned,
           ls_size, robidx_flag, robidx,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, prd, imm, src1, src2, is_load, is_store, is_unsigned,
           ls_size, robidx_flag, robidx,
    output instr_ready
  );

endinterface

// File: rtl/mem_issue_queue_rob_age_cmp.sv
// ROB age compare: a_younger is set when tag A is strictly younger than tag B.
module rob_age_cmp
  import mem_issue_queue_pkg::*;
(
  input  logic             a_flag,
  input  logic [ROB_W-1:0] a_idx,
  input  logic             b_flag,
  input  logic [ROB_W-1:0] b_idx,
  output logic             a_younger
);

  // Differing flags mean one tag has wrapped, which inverts the index order.
  assign a_younger = (a_flag ^ b_flag) ^ (b_idx < a_idx);

endmodule

// File: rtl/mem_issue_queue.sv
// In-order data-capture issue queue for load/store ops; only the head may issue,
// operands are captured from writeback broadcasts, and a redirect trims the young suffix.
module mem_issue_queue
  import mem_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  input  logic [PREG_W-1:0]    enq_prd,
  input  logic [PREG_W-1:0]    enq_prs1,
  input  logic [PREG_W-1:0]    enq_prs2,
  input  logic                 enq_src1_rdy,
  input  logic                 enq_src2_rdy,
  input  logic [XLEN-1:0]      enq_src1,
  input  logic [XLEN-1:0]      enq_src2,
  input  logic [XLEN-1:0]      enq_imm,
  input  logic                 enq_is_load,
  input  logic                 enq_is_store,
  input  logic                 enq_is_unsigned,
  input  logic [LS_SIZE_W-1:0] enq_ls_size,
  input  logic                 enq_robidx_flag,
  input  logic [ROB_W-1:0]     enq_robidx,
  input  logic                 wb0_valid,
  input  logic [PREG_W-1:0]    wb0_prd,
  input  logic [XLEN-1:0]      wb0_data,
  input  logic                 wb1_valid,
  input  logic [PREG_W-1:0]    wb1_prd,
  input  logic [XLEN-1:0]      wb1_data,
  input  logic                 flush_valid,
  input  logic                 flush_robidx_flag,
  input  logic [ROB_W-1:0]     flush_robidx,
  output logic [PTR_W:0]       iq_count,
  mem_issue_queue_if.master    iss
);

  iq_ctl_t ctl [DEPTH];
  iq_pay_t pay [DEPTH];

  logic [PTR_W:0]   head, tail, survivors;
  logic [PTR_W-1:0] head_idx, tail_idx;
  logic             full, empty, enq_fire, issue, deq_fire;
  logic [DEPTH-1:0] younger, kill;

  logic [NUM_WB-1:0]             wb_valid;
  logic [NUM_WB-1:0][PREG_W-1:0] wb_prd;
  logic [NUM_WB-1:0][XLEN-1:0]   wb_data;

  wake_t   w1 [DEPTH];
  wake_t   w2 [DEPTH];
  wake_t   enq_w1, enq_w2;
  iq_pay_t enq_pay;

  assign wb_valid = {wb1_valid, wb0_valid};
  assign wb_prd   = {wb1_prd, wb0_prd};
  assign wb_data  = {wb1_data, wb0_data};

  assign head_idx  = head[PTR_W-1:0];
  assign tail_idx  = tail[PTR_W-1:0];
  assign full      = (head_idx == tail_idx) && (head[PTR_W] != tail[PTR_W]);
  assign empty     = (head == tail);
  assign enq_ready = ~full;
  assign enq_fire  = enq_valid & ~full & ~flush_valid;
  assign iq_count  = tail - head;

  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    rob_age_cmp u_age (
      .a_flag    (pay[i].robidx_flag),
      .a_idx     (pay[i].robidx),
      .b_flag    (flush_robidx_flag),
      .b_idx     (flush_robidx),
      .a_younger (younger[i])
    );
    assign kill[i] = flush_valid & ctl[i].valid & younger[i];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w1[i] = wake_sel(pay[i].prs1, wb_valid, wb_prd, wb_data);
      w2[i] = wake_sel(pay[i].prs2, wb_valid, wb_prd, wb_data);
    end
    enq_w1 = wake_sel(enq_prs1, wb_valid, wb_prd, wb_data);
    enq_w2 = wake_sel(enq_prs2, wb_valid, wb_prd, wb_data);
    // Kills form a suffix, so the survivor count alone locates the new tail.
    survivors = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ctl[i].valid && !kill[i]) survivors = survivors + (PTR_W+1)'(1);
    end
  end

  always_comb begin
    enq_pay             = '0;
    enq_pay.prd         = enq_prd;
    enq_pay.prs1        = enq_prs1;
    enq_pay.prs2        = enq_prs2;
    enq_pay.src1        = enq_src1_rdy ? enq_src1 : enq_w1.data;
    enq_pay.src2        = enq_src2_rdy ? enq_src2 : enq_w2.data;
    enq_pay.imm         = enq_imm;
    enq_pay.is_load     = enq_is_load;
    enq_pay.is_store    = enq_is_store;
    enq_pay.is_unsigned = enq_is_unsigned;
    enq_pay.ls_size     = enq_ls_size;
    enq_pay.robidx_flag = enq_robidx_flag;
    enq_pay.robidx      = enq_robidx;
  end

  assign issue = ctl[head_idx].valid & ctl[head_idx].rdy1 &
                 (pay[head_idx].is_load | ctl[head_idx].rdy2) & ~flush_valid;
  assign deq_fire = issue & iss.instr_ready;

  assign iss.instr_valid = issue;
  assign iss.prd         = empty ? '0   : pay[head_idx].prd;
  assign iss.imm         = empty ? '0   : pay[head_idx].imm;
  assign iss.src1        = empty ? '0   : pay[head_idx].src1;
  assign iss.src2        = empty ? '0   : pay[head_idx].src2;
  assign iss.is_load     = empty ? 1'b0 : pay[head_idx].is_load;
  assign iss.is_store    = empty ? 1'b0 : pay[head_idx].is_store;
  assign iss.is_unsigned = empty ? 1'b0 : pay[head_idx].is_unsigned;
  assign iss.ls_size     = empty ? '0   : pay[head_idx].ls_size;
  assign iss.robidx_flag = empty ? 1'b0 : pay[head_idx].robidx_flag;
  assign iss.robidx      = empty ? '0   : pay[head_idx].robidx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) ctl[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill[i]) ctl[i].valid <= 1'b0;
        if (ctl[i].valid && !ctl[i].rdy1 && w1[i].hit) ctl[i].rdy1 <= 1'b1;
        if (ctl[i].valid && !ctl[i].rdy2 && w2[i].hit) ctl[i].rdy2 <= 1'b1;
      end
      if (deq_fire) begin
        ctl[head_idx].valid <= 1'b0;
        head                <= head + (PTR_W+1)'(1);
      end
      if (flush_valid) begin
        tail <= head + survivors;
      end else if (enq_fire) begin
        tail          <= tail + (PTR_W+1)'(1);
        ctl[tail_idx] <= '{valid: 1'b1,
                           rdy1:  enq_src1_rdy | enq_w1.hit,
                           rdy2:  enq_src2_rdy | enq_w2.hit};
      end
    end
  end

  // Payload storage carries no reset; validity lives in ctl.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (ctl[i].valid && !ctl[i].rdy1 && w1[i].hit) pay[i].src1 <= w1[i].data;
      if (ctl[i].valid && !ctl[i].rdy2 && w2[i].hit) pay[i].src2 <= w2[i].data;
    end
    if (enq_fire) pay[tail_idx] <= enq_pay;
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue: issue, wakeup, ordering, full, flush and async reset.
module tb_mem_issue_queue;
  import mem_issue_queue_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 enq_valid = 1'b0;
  logic                 enq_ready;
  logic [PREG_W-1:0]    enq_prd = '0, enq_prs1 = '0, enq_prs2 = '0;
  logic                 enq_src1_rdy = 1'b0, enq_src2_rdy = 1'b0;
  logic [XLEN-1:0]      enq_src1 = '0, enq_src2 = '0, enq_imm = '0;
  logic                 enq_is_load = 1'b0, enq_is_store = 1'b0, enq_is_unsigned = 1'b0;
  logic [LS_SIZE_W-1:0] enq_ls_size = '0;
  logic                 enq_robidx_flag = 1'b0;
  logic [ROB_W-1:0]     enq_robidx = '0;
  logic                 wb0_valid = 1'b0, wb1_valid = 1'b0;
  logic [PREG_W-1:0]    wb0_prd = '0, wb1_prd = '0;
  logic [XLEN-1:0]      wb0_data = '0, wb1_data = '0;
  logic                 flush_valid = 1'b0, flush_robidx_flag = 1'b0;
  logic [ROB_W-1:0]     flush_robidx = '0;
  logic [3:0]           iq_count;

  int n_tests = 0;
  int n_fail  = 0;

  mem_issue_queue_if iss_if ();

  mem_issue_queue #(.DEPTH(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_prd(enq_prd), .enq_prs1(enq_prs1), .enq_prs2(enq_prs2),
    .enq_src1_rdy(enq_src1_rdy), .enq_src2_rdy(enq_src2_rdy),
    .enq_src1(enq_src1), .enq_src2(enq_src2), .enq_imm(enq_imm),
    .enq_is_load(enq_is_load), .enq_is_store(enq_is_store), .enq_is_unsigned(enq_is_unsigned),
    .enq_ls_size(enq_ls_size), .enq_robidx_flag(enq_robidx_flag), .enq_robidx(enq_robidx),
    .wb0_valid(wb0_valid), .wb0_prd(wb0_prd), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_prd(wb1_prd), .wb1_data(wb1_data),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag), .flush_robidx(flush_robidx),
    .iq_count(iq_count), .iss(iss_if)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, then clear single-cycle pulses and let logic settle.
  task automatic step();
    @(posedge clock);
    #1;
    enq_valid   = 1'b0;
    wb0_valid   = 1'b0;
    wb1_valid   = 1'b0;
    flush_valid = 1'b0;
    #1;
  endtask

  task automatic set_enq(input logic ld, input logic st, input logic [PREG_W-1:0] p1,
                         input logic [PREG_W-1:0] p2, input logic r1, input logic r2,
                         input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                         input logic [XLEN-1:0] imm, input logic fl, input logic [ROB_W-1:0] rob);
    enq_valid       = 1'b1;
    enq_is_load     = ld;
    enq_is_store    = st;
    enq_prs1        = p1;
    enq_prs2        = p2;
    enq_src1_rdy    = r1;
    enq_src2_rdy    = r2;
    enq_src1        = s1;
    enq_src2        = s2;
    enq_imm         = imm;
    enq_robidx_flag = fl;
    enq_robidx      = rob;
    enq_prd         = 6'd40;
    enq_ls_size     = 4'b1000;
  endtask

  task automatic push(input logic ld, input logic st, input logic [PREG_W-1:0] p1,
                      input logic [PREG_W-1:0] p2, input logic r1, input logic r2,
                      input logic [XLEN-1:0] s1, input logic [XLEN-1:0] s2,
                      input logic [XLEN-1:0] imm, input logic fl, input logic [ROB_W-1:0] rob);
    set_enq(ld, st, p1, p2, r1, r2, s1, s2, imm, fl, rob);
    step();
  endtask

  task automatic wb(input int port, input logic [PREG_W-1:0] p, input logic [XLEN-1:0] d);
    if (port == 0) begin wb0_valid = 1'b1; wb0_prd = p; wb0_data = d; end
    else           begin wb1_valid = 1'b1; wb1_prd = p; wb1_data = d; end
  endtask

  initial begin
    iss_if.instr_ready = 1'b0;
    #12;
    check("rst_valid", iss_if.instr_valid, 0);
    check("rst_count", iq_count, 0);
    check("rst_enq_ready", enq_ready, 1);
    check("rst_src1", iss_if.src1, 0);
    check("rst_robidx", iss_if.robidx, 0);
    reset_n = 1'b1;
    step();

    // Ready-at-dispatch load
    iss_if.instr_ready = 1'b1;
    push(1, 0, 6'd5, 6'd0, 1, 0, 64'h1000, 0, 64'd8, 0, 5'd3);
    check("ld_valid", iss_if.instr_valid, 1);
    check("ld_src1", iss_if.src1, 64'h1000);
    check("ld_imm", iss_if.imm, 8);
    check("ld_robidx", iss_if.robidx, 3);
    check("ld_count1", iq_count, 1);
    step();
    check("ld_count0", iq_count, 0);
    check("ld_gone", iss_if.instr_valid, 0);

    // Wakeup capture; wb0 beats wb1 on the same preg
    push(0, 1, 6'd3, 6'd12, 1, 0, 64'h2000, 0, 0, 0, 5'd4);
    check("st_wait0", iss_if.instr_valid, 0);
    step();
    check("st_wait1", iss_if.instr_valid, 0);
    wb(0, 6'd12, 64'hDEAD);
    wb(1, 6'd12, 64'hBEEF);
    #1;
    check("st_wait_wbcyc", iss_if.instr_valid, 0);
    step();
    check("st_woke", iss_if.instr_valid, 1);
    check("st_src2", iss_if.src2, 64'hDEAD);
    check("st_is_store", iss_if.is_store, 1);
    step();
    check("st_count0", iq_count, 0);

    // Wakeup in the enqueue cycle itself
    set_enq(1, 0, 6'd7, 6'd0, 0, 0, 0, 0, 0, 0, 5'd5);
    wb(1, 6'd7, 64'h77);
    step();
    check("byp_valid", iss_if.instr_valid, 1);
    check("byp_src1", iss_if.src1, 64'h77);
    step();

    // preg 0 broadcast never wakes; older flush tag then removes the entry
    push(1, 0, 6'd0, 6'd0, 0, 0, 0, 0, 0, 0, 5'd10);
    wb(0, 6'd0, 64'h55);
    step();
    check("p0_nowake", iss_if.instr_valid, 0);
    flush_valid = 1'b1; flush_robidx_flag = 1'b0; flush_robidx = 5'd9;
    step();
    check("p0_flushed", iq_count, 0);

    // In-order blocking
    push(0, 1, 6'd3, 6'd20, 1, 0, 64'h3000, 0, 0, 0, 5'd11);
    push(1, 0, 6'd4, 6'd0, 1, 0, 64'hAAA, 0, 0, 0, 5'd12);
    check("ord_block", iss_if.instr_valid, 0);
    check("ord_count", iq_count, 2);
    step();
    check("ord_block2", iss_if.instr_valid, 0);
    wb(1, 6'd20, 64'h1234);
    step();
    check("ord_st_valid", iss_if.instr_valid, 1);
    check("ord_st_src2", iss_if.src2, 64'h1234);
    check("ord_st_first", iss_if.is_store, 1);
    step();
    check("ord_ld_valid", iss_if.instr_valid, 1);
    check("ord_ld_second", iss_if.is_load, 1);
    check("ord_ld_src1", iss_if.src1, 64'hAAA);
    step();
    check("ord_count0", iq_count, 0);

    // Backpressure and full
    iss_if.instr_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      push(1, 0, 6'd1, 6'd0, 1, 0, 64'h100 + 64'(i), 0, 0, 0, 5'(16 + i));
    check("full_enq_ready", enq_ready, 0);
    check("full_count", iq_count, 8);
    check("full_head", iss_if.src1, 64'h100);
    step();
    check("full_stable", iss_if.src1, 64'h100);
    set_enq(1, 0, 6'd1, 6'd0, 1, 0, 64'h999, 0, 0, 0, 5'd30);
    iss_if.instr_ready = 1'b1;
    #1;
    check("full_no_credit", enq_ready, 0);
    step();
    iss_if.instr_ready = 1'b0;
    check("full_pop_count", iq_count, 7);
    check("full_next_head", iss_if.src1, 64'h101);
    iss_if.instr_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("full_drained", iq_count, 0);

    // Flush keeps robidx 4,5; enqueue and issue suppressed that cycle
    iss_if.instr_ready = 1'b0;
    for (int i = 4; i < 8; i++) push(1, 0, 6'd1, 6'd0, 1, 0, 0, 0, 0, 0, 5'(i));
    flush_valid = 1'b1; flush_robidx_flag = 1'b0; flush_robidx = 5'd5;
    set_enq(1, 0, 6'd1, 6'd0, 1, 0, 0, 0, 0, 0, 5'd8);
    #1;
    check("fl_no_issue", iss_if.instr_valid, 0);
    step();
    check("fl_count", iq_count, 2);
    check("fl_head", iss_if.robidx, 4);
    iss_if.instr_ready = 1'b1;
    step();
    check("fl_second", iss_if.robidx, 5);
    step();
    check("fl_drained", iq_count, 0);

    // Wrap-around flush; survivor still wakes during the flush cycle
    iss_if.instr_ready = 1'b0;
    push(1, 0, 6'd9, 6'd0, 0, 0, 0, 0, 0, 0, 5'd30);
    push(1, 0, 6'd1, 6'd0, 1, 0, 0, 0, 0, 0, 5'd31);
    push(1, 0, 6'd1, 6'd0, 1, 0, 0, 0, 0, 1, 5'd0);
    push(1, 0, 6'd1, 6'd0, 1, 0, 0, 0, 0, 1, 5'd1);
    flush_valid = 1'b1; flush_robidx_flag = 1'b0; flush_robidx = 5'd31;
    wb(0, 6'd9, 64'h99);
    step();
    check("wrap_count", iq_count, 2);
    check("wrap_head", iss_if.robidx, 30);
    check("wrap_woke", iss_if.instr_valid, 1);
    check("wrap_src1", iss_if.src1, 64'h99);
    iss_if.instr_ready = 1'b1;
    step();
    check("wrap_second", iss_if.robidx, 31);
    check("wrap_second_flag", iss_if.robidx_flag, 0);
    step();
    check("wrap_drained", iq_count, 0);

    // Async reset mid-stall
    iss_if.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(1, 0, 6'd1, 6'd0, 1, 0, 64'h50 + 64'(i), 0, 0, 0, 5'(i));
    check("ar_count5", iq_count, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid", iss_if.instr_valid, 0);
    check("ar_count", iq_count, 0);
    check("ar_enq_ready", enq_ready, 1);
    check("ar_src1", iss_if.src1, 0);
    #3;
    reset_n = 1'b1;
    step();
    check("ar_count_after", iq_count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_issue_queue.md
Name: mem_issue_queue

Overview:
- In-order, data-capture issue queue for load/store micro-ops; sits between dispatch/rename and memblock.
- Holds up to DEPTH memory ops in program order and captures source operand values from writeback broadcasts.
- Presents the oldest ready op to memblock over the instr_valid/instr_ready handshake, in strict program order with no reordering.
- Removes entries younger than a redirect flush.

Parameters:
- DEPTH, 8, entry count; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), index width. Head/tail pointers are PTR_W+1 bits, including a wrap bit.

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- enq_valid  in  1  dispatch offers one op
- enq_ready  out  1  queue can accept (~full)
- enq_prd  in  `PREG_RANGE  destination preg
- enq_prs1, enq_prs2  in  `PREG_RANGE  source pregs
- enq_src1_rdy, enq_src2_rdy  in  1  operand already available at dispatch
- enq_src1, enq_src2  in  `SRC_RANGE  operand values, valid when the matching rdy bit is 1
- enq_imm  in  `SRC_RANGE  immediate
- enq_is_load, enq_is_store, enq_is_unsigned  in  1  op class
- enq_ls_size  in  `LS_SIZE_RANGE  one-hot size (b/h/w/d)
- enq_robidx_flag  in  1, enq_robidx  in  `ROB_SIZE_LOG  ROB tag
- wb0_valid, wb1_valid  in  1  writeback broadcasts (wb0 = ALU, wb1 = memblock)
- wb0_prd, wb1_prd  in  `PREG_RANGE; wb0_data, wb1_data  in  `RESULT_RANGE
- instr_valid  out  1  to memblock
- instr_ready  in  1  from memblock
- prd, imm, src1, src2, is_load, is_store, is_unsigned, ls_size, robidx_flag, robidx  out  same widths as the enq_* fields  head entry payload
- flush_valid  in  1, flush_robidx_flag  in  1, flush_robidx  in  `ROB_SIZE_LOG  redirect
- iq_count  out  PTR_W+1  occupancy

Behaviour:
- Reset: all entries invalid; head = tail = 0; enq_ready = 1; instr_valid = 0; all payload outputs 0.
- Enqueue fires when enq_valid & enq_ready & ~flush_valid. The entry is written at tail; tail increments by 1 with wrap bit toggling at DEPTH.
- enq_ready = ~full, where full = (head.idx == tail.idx) & (head.wrap != tail.wrap). No same-cycle dequeue credit: a full queue stays not-ready during a pop cycle.
- Wakeup, every cycle, for each valid entry and each source not yet ready:
  - If wbN_valid & wbN_prd == prsX, set the ready bit and capture wbN_data.
  - If both ports match the same source in one cycle, wb0 wins.
- Enqueue bypass: a wakeup matching enq_prs1/prs2 in the enqueue cycle is captured into the new entry, so the entry is written ready.
- preg 0 is never a wakeup target. A broadcast with prd = 0 is ignored.
- Issue (combinational from head):
  - instr_valid = head valid & src1_rdy & (is_load | src2_rdy) & ~flush_valid.
  - Payload outputs are driven from the head entry whenever the queue is non-empty, and 0 when empty.
  - Only the head issues; a non-ready head blocks all younger entries.
- Dequeue: instr_valid & instr_ready pops the head at the clock edge, and head increments. Head fields are held stable while instr_valid & ~instr_ready.
- Flush, when flush_valid is high:
  - An entry is killed when (flush_robidx_flag ^ entry_flag) ^ (flush_robidx < entry_robidx) is 1, i.e. the entry is strictly younger than the flush tag.
  - Killed entries always form a suffix of the queue. Tail is set to head + (number of survivors).
  - Enqueue and issue are both suppressed that cycle.
  - Wakeup of surviving entries still happens.
- iq_count = tail - head (PTR_W+1 arithmetic).
- Simultaneous pop and push at occupancy DEPTH-1 or lower: both take effect; count unchanged.
- Reset asserted mid-operation clears everything asynchronously. No partially written entry survives.

Decomposition:
- Shared package/defines: entry struct typedef (valid, prd, prs1/2, rdy1/2, src1/2, imm, op bits, ls_size, rob tag) and the wakeup-port count constant. `PREG_RANGE, `SRC_RANGE, `ROB_SIZE_LOG and `LS_SIZE_RANGE come from the existing defines.
- One natural sub-module: rob_age_cmp. It is combinational: flag/idx of A and B in, a_younger out. It is instantiated per entry for flush kill, and is reusable by memblock and other queues.

Test Plan:
- Ready-at-dispatch load: enq load robidx 3, src1_rdy = 1, src1 = 0x1000, imm = 8, instr_ready = 1 -> instr_valid the next cycle with src1 = 0x1000, imm = 8; pop; iq_count returns to 0.
- Wakeup capture: enq store prs2 = 12 with src2_rdy = 0; two cycles later wb0_valid, wb0_prd = 12, wb0_data = 0xDEAD -> instr_valid asserted the cycle after, with src2 = 0xDEAD. Also, a wakeup in the enqueue cycle itself -> entry written ready.
- In-order blocking: head is a non-ready store, second entry is a ready load -> instr_valid = 0 until the store's operand arrives. Then the store issues, then the load.
- Backpressure and full: fill 8 entries with instr_ready = 0 -> enq_ready = 0, iq_count = 8, head payload stable. Raise ready for one cycle while enq_valid = 1 -> only the pop occurs; iq_count = 7.
- Flush: queue holds robidx 4, 5, 6, 7 (flag 0); flush robidx 5 flag 0 -> survivors 4 and 5, iq_count = 2, and no issue that cycle. Wrap case: entries flag 0 idx 30, 31 and flag 1 idx 0, 1; flush flag 0 idx 31 -> survivors 30 and 31.
- Async reset mid-stall with 5 entries -> instr_valid = 0, iq_count = 0, enq_ready = 1 immediately.
